mdu: RTL
========

# mdu

Multiply/divide unit for the pipelined MIPS core, in the E stage directly downstream of `grf`: it consumes the two operands read from the register file (forwarded through the D/E register) and owns the HI/LO registers whose values return to `grf` through `mfhi`/`mflo` on the writeback path. Multi-cycle multiply and divide are modelled with a fixed-latency busy window, which the hazard unit uses to stall dependent instructions.

## Interface
- `MULT_LAT`, 5: cycles `busy` stays high for multiply-class ops; legal range 1..15.
- `DIV_LAT`, 10: cycles `busy` stays high for divide ops; legal range 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe; `op`, `A`, `B` are sampled when it is high.
- `op`  in  4  operation, encoded per `mdu_pkg`.
- `A`  in  32  operand rs (grf RD1, after forwarding).
- `B`  in  32  operand rt (grf RD2, after forwarding).
- `busy`  out  1  high while a multi-cycle op is in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- Ops: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10. Codes 11–15 are treated as NONE.
- FSM has two states, IDLE and RUN, plus a 4-bit down-counter `cnt`.
- IDLE with `start=1` and a MULT/MULTU/DIV/DIVU (or enabled MADD-class) op:
  - `A`, `B` and `op` are latched.
  - `cnt` loads the op's latency and the FSM enters RUN.
- IDLE with `start=1` and MTHI/MTLO: `HI<=A` or `LO<=A` at that edge. No busy cycle.
- RUN: `cnt` decrements each cycle. When `cnt==1`, the result is written to HI/LO and the FSM returns to IDLE.
- Ops with `start=1` in RUN, including MTHI/MTLO, are ignored. Upstream stall logic keeps them from occurring.
- MULT: {HI,LO} = signed 64-bit A*B. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor 0 (DIV/DIVU): the busy window runs normally, and HI/LO are left unchanged.
- The result is computed from the latched operands. Input changes during RUN have no effect.

## Timing
- Reset values: `HI`=0, `LO`=0, `busy`=0, FSM in IDLE, `cnt`=0.
- Start at edge t with latency L:
  - `busy`=1 during cycles t+1 .. t+L.
  - New HI/LO are visible from cycle t+L+1.
  - `busy`=0 in cycle t+L+1.
- A new start is accepted in cycle t+L+1, back-to-back with no gap cycle.
- MTHI/MTLO at edge t: new value visible in cycle t+1. `busy` stays 0.
- `busy` is a registered output. It does not include the current `start`; the hazard unit ORs `start` in itself.
- `rst` overrides everything, including mid-RUN and simultaneous `start`:
  - FSM returns to IDLE, HI/LO clear to 0, `busy`=0 on the next cycle.
  - The in-flight op is discarded.

## Configuration
- `MDU_MADD_EN` defined:
  - MADD/MADDU: {HI,LO} += A*B (signed/unsigned 64-bit product), wrapping mod 2^64.
  - MSUB/MSUBU: {HI,LO} -= A*B, wrapping mod 2^64.
  - All use `MULT_LAT`. The accumulate reads HI/LO at the result-write edge.
- Undefined: op codes 7–10 behave as NONE. They do not assert `busy` and do not modify HI/LO.

## Structure
- `mdu_pkg` holds:
  - op encoding localparams (`MDU_NONE` .. `MDU_MSUBU`);
  - FSM state encoding;
  - default `MULT_LAT`/`DIV_LAT` constants.
  - The controller's op decoder imports it.
- Sub-module `mdu_calc` is purely combinational. From the latched op/operands and current HI/LO it produces next {HI,LO} and a write-enable, which is low for divide-by-zero and NONE.
- `mdu` holds the FSM, counter, operand latches and the HI/LO registers.

## Test plan
- Reset then MULT with A=0xFFFFFFFF (-1), B=2:
  - `busy` high for exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- DIV with A=-7 (0xFFFFFFF9), B=2: after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 after HI=LO=0x12345678: HI/LO unchanged, `busy` still high for 10 cycles.
- MTHI A=0xDEADBEEF, then MTLO A=0x1 on the next cycle:
  - `busy` never asserts;
  - HI=0xDEADBEEF and LO=0x1 one cycle after each write.
- MULT in flight, then MTLO and DIV strobed during RUN: both are ignored, and the MULT result is unaltered.
  - A start on the cycle `busy` falls is accepted back-to-back.
- `rst` asserted at busy cycle 3 of a DIV, together with `start`=MULT: next cycle HI=LO=0, `busy`=0, and no later result write.
- With `MDU_MADD_EN`, HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 gives HI=1, LO=0.
  - Without the macro, op 8 leaves HI/LO and `busy` unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encoding (MDU_NONE .. MDU_MSUBU), 4 bits wide
//   - controller state encoding
//   - default multiply/divide latencies
//   - op-class decode helpers used by the controller
// Optional feature macro: MDU_MADD_EN. When it is defined, the MADD/MADDU/MSUB/MSUBU
// ops become multiply-class ops. When it is undefined, they decode as NONE.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Multiply-class ops run for MULT_LAT cycles.
  // MADD-class ops count as multiply-class only when the feature is built in.
  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result datapath for the multiply/divide unit.
// Inputs : op     latched operation code
//          a, b   latched operands (rs, rt)
//          hi, lo current HI/LO values; the accumulate ops read these
// Outputs: hi_nx, lo_nx  next HI/LO values
//          we            write enable; low for NONE/unknown ops and for a zero divisor
// Optional feature macro: MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_nx,
  output logic [31:0] lo_nx,
  output logic        we
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvs_s;
  logic [31:0] dvs_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [63:0] res;

  // Signed product from explicit sign extension to 64 bits.
  // The low 64 bits of this product are the two's-complement signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes. 0x80000000 stays 0x80000000 as an unsigned
  // magnitude, so 0x80000000 / -1 wraps to 0x80000000 with remainder 0 and never
  // overflows. A zero divisor is steered to 1 to keep the dividers well defined.
  // Its result is never written back.
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign dvs_s = (b == 32'd0) ? 32'd1 : abs_b;
  assign dvs_u = (b == 32'd0) ? 32'd1 : b;
  assign q_mag = abs_a / dvs_s;
  assign r_mag = abs_a % dvs_s;
  // Quotient truncates toward zero. The remainder takes the sign of the dividend.
  assign q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = a / dvs_u;
  assign r_u   = a % dvs_u;

  always_comb begin
    res = {hi, lo};
    we  = 1'b0;
    case (op)
      MDU_MULT:  begin res = prod_s;     we = 1'b1; end
      MDU_MULTU: begin res = prod_u;     we = 1'b1; end
      MDU_DIV:   begin res = {r_s, q_s}; we = (b != 32'd0); end
      MDU_DIVU:  begin res = {r_u, q_u}; we = (b != 32'd0); end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin res = {hi, lo} + prod_s; we = 1'b1; end
      MDU_MADDU: begin res = {hi, lo} + prod_u; we = 1'b1; end
      MDU_MSUB:  begin res = {hi, lo} - prod_s; we = 1'b1; end
      MDU_MSUBU: begin res = {hi, lo} - prod_u; we = 1'b1; end
`endif
      default:   begin res = {hi, lo};   we = 1'b0; end
    endcase
  end

  assign hi_nx = res[63:32];
  assign lo_nx = res[31:0];

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with the HI/LO registers, in the E stage.
// Parameters: MULT_LAT (1..15) busy cycles for multiply-class ops
//             DIV_LAT  (1..15) busy cycles for divide ops
// Ports: clk, rst (sync, active high)
//        start, op[3:0], A[31:0], B[31:0]  issue interface
//        busy       registered; high while a multi-cycle op is in flight
//        HI, LO     architectural HI/LO registers
//        dbg_state  current controller state
// Handshake: an op is accepted on a rising edge when start=1 and the unit is
// IDLE. While RUN, start is ignored; the hazard unit stalls issue while busy is
// high (it ORs start into its own stall term). There is no ready output.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output mdu_state_e  dbg_state
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_we;

  mdu_calc u_calc (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .hi    (hi_q),
    .lo    (lo_q),
    .hi_nx (calc_hi),
    .lo_nx (calc_lo),
    .we    (calc_we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul_op(op) || is_div_op(op)) begin
            op_d    = op;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_div_op(op) ? DIV_CNT : MULT_CNT;
            state_d = ST_RUN;
          end else if (op == MDU_MTHI) begin
            hi_d = A;
          end else if (op == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        // The result is written on the edge where cnt==1. It becomes visible
        // in the same cycle that busy drops, so back-to-back issue sees it.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (calc_we) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MDU_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state_q;

endmodule
